// File: rtl/dnn_pkg.sv
// Shared constants and types for the DNN output streaming path.
package dnn_pkg;
  localparam int DW         = 32;
  localparam int AW         = 12;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PW    = 2;
  localparam int FIFO_CW    = 3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/dst_stream_if.sv
// Result-buffer read port plus AXI-stream-style output, bundled for dst_stream.
interface dst_stream_if #(
   parameter int DW = dnn_pkg::DW,
   parameter int AW = dnn_pkg::AW
);
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          dst_valid;
   logic [DW-1:0] dst_data;
   logic          dst_last;
   logic          dst_ready;

   modport master (
      output rd_en, rd_addr, dst_valid, dst_data, dst_last,
      input  rd_data, dst_ready
   );
   modport slave (
      input  rd_en, rd_addr, dst_valid, dst_data, dst_last,
      output rd_data, dst_ready
   );
endinterface

// File: rtl/dst_fifo.sv
// 4-entry FIFO; the head word is presented combinationally on dout.
module dst_fifo
   import dnn_pkg::*;
#(
   parameter int W = DW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic [W-1:0]       din,
   output logic [W-1:0]       dout,
   output logic               full,
   output logic               empty,
   output logic [FIFO_CW-1:0] count
);
   logic [W-1:0]       mem [FIFO_DEPTH];
   logic [FIFO_PW-1:0] wptr, rptr;
   logic [FIFO_CW-1:0] cnt;
   logic               do_push, do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Storage is cleared on reset so the head (dst_data) reads zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wptr] <= din;
            wptr      <= wptr + 1'b1;
         end
         if (do_pop) rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: ;
         endcase
      end
   end

   assign full  = (cnt == FIFO_CW'(FIFO_DEPTH));
   assign empty = (cnt == '0);
   assign dout  = mem[rptr];
   assign count = cnt;
endmodule

// File: rtl/dst_stream.sv
// Streams ds result-buffer words out over a valid/ready port, with optional
// ReLU, through a 4-deep FIFO that absorbs the one-cycle read latency.
module dst_stream #(
   parameter int DW = dnn_pkg::DW,
   parameter int AW = dnn_pkg::AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] ds,
   input  logic          relu,
   output logic          busy,
   output logic          done,
   dst_stream_if.master  bus
);
   import dnn_pkg::*;

   state_t                state;
   logic [AW-1:0]         ds_q, beat_cnt, rd_addr_q;
   logic                  relu_q, rd_en_q, ret_vld, done_q;
   logic [FIFO_CW-1:0]    occ;
   logic                  full, empty, hs, last_beat, can_issue;
   logic [DW-1:0]         wdata, head;
   logic [FIFO_CW:0]      pending;

   // Words committed to the FIFO: stored, returning this cycle, or being read.
   assign pending   = {1'b0, occ} + (FIFO_CW+1)'(rd_en_q) + (FIFO_CW+1)'(ret_vld);
   assign can_issue = (pending < (FIFO_CW+1)'(FIFO_DEPTH)) && !full;
   assign hs        = !empty && bus.dst_ready;
   assign last_beat = (beat_cnt == ds_q - 1'b1);
   assign wdata     = (relu_q && bus.rd_data[DW-1]) ? '0 : bus.rd_data;

   dst_fifo #(.W(DW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (ret_vld),
      .pop   (hs),
      .din   (wdata),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (occ)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ds_q      <= '0;
         relu_q    <= 1'b0;
         beat_cnt  <= '0;
         rd_addr_q <= '0;
         rd_en_q   <= 1'b0;
         ret_vld   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         ret_vld <= rd_en_q;
         if (hs) beat_cnt <= beat_cnt + 1'b1;
         case (state)
            IDLE: begin
               rd_en_q <= 1'b0;
               if (start) begin
                  ds_q     <= ds;
                  relu_q   <= relu;
                  beat_cnt <= '0;
                  if (ds == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     rd_en_q   <= 1'b1;
                     rd_addr_q <= '0;
                     state     <= (ds == AW'(1)) ? DRAIN : RUN;
                  end
               end
            end
            RUN: begin
               if (can_issue) begin
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= rd_addr_q + 1'b1;
                  if (rd_addr_q + 1'b1 == ds_q - 1'b1) state <= DRAIN;
               end else begin
                  rd_en_q <= 1'b0;
               end
            end
            DRAIN: begin
               rd_en_q <= 1'b0;
               if (hs && last_beat) begin
                  state  <= IDLE;
                  done_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy          = (state != IDLE);
   assign done          = done_q;
   assign bus.rd_en     = rd_en_q;
   assign bus.rd_addr   = rd_addr_q;
   assign bus.dst_valid = !empty;
   assign bus.dst_data  = head;
   assign bus.dst_last  = !empty && last_beat;
endmodule

// File: doc/dst_stream.md
DST_STREAM -- requirements
Module: dst_stream

Interface
REQ-001 SHALL have parameter DW, default 32: data word width; carries IEEE-754 fp32 bits.
REQ-002 SHALL have parameter AW, default 12: result-buffer address width.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1: one-cycle pulse that begins one output transfer.
REQ-006 SHALL have port ds, input, AW: number of words to stream; it is sampled with start.
REQ-007 SHALL have port relu, input, 1: activation enable; it is sampled with start.
REQ-008 SHALL have port rd_en, output, 1: result-buffer read strobe.
REQ-009 SHALL have port rd_addr, output, AW: result-buffer read address.
REQ-010 SHALL have port rd_data, input, DW: result-buffer data, valid one cycle after rd_en.
REQ-011 SHALL have ports dst_valid (output, 1), dst_data (output, DW), dst_last (output, 1) and dst_ready (input, 1): the AXI-stream-style output.
REQ-012 SHALL have port busy, output, 1: high while a transfer is in progress.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when a transfer completes.

Function
REQ-014 SHALL use the states IDLE, RUN and DRAIN.
REQ-015 IDLE->RUN on start with ds!=0; RUN->DRAIN when the read for address ds-1 is issued; DRAIN->IDLE on the handshake of the last word.
REQ-016 start with ds==0 SHALL stay in IDLE, pulse done on the next cycle, and emit no stream beat.
REQ-017 start while busy SHALL be ignored; ds and relu SHALL be ignored outside the start cycle.
REQ-018 Reads SHALL be issued in order at addresses 0..ds-1, one per cycle at most.
REQ-019 A read SHALL be issued only when (FIFO occupancy + reads in flight) < 4, counted before this cycle's pop.
REQ-020 The returned rd_data SHALL be written into a 4-entry FIFO; the FIFO head SHALL drive dst_data, and dst_valid SHALL equal "FIFO not empty".
REQ-021 Latency: with start sampled at edge E0, rd_en SHALL be high after E0 and dst_valid SHALL first be high after E2.
REQ-022 With dst_ready held high, the block SHALL sustain one beat per cycle with no bubbles after the first beat.
REQ-023 A handshake SHALL be dst_valid&dst_ready; dst_data and dst_last SHALL hold stable while dst_valid&!dst_ready.
REQ-024 dst_valid SHALL NOT drop without a handshake.
REQ-025 dst_last SHALL be high only on word index ds-1.
REQ-026 When relu is set, any word with sign bit 1 (including -0.0) SHALL be emitted as 32'h00000000; other words SHALL pass bit-exact.
REQ-027 The relu decision SHALL be applied at FIFO write.
REQ-028 busy SHALL be high in RUN and DRAIN.
REQ-029 done SHALL pulse one cycle after the last handshake, when busy has already dropped.
REQ-030 A new start SHALL be accepted in the cycle done is high.
REQ-031 The FIFO SHALL never overflow.
REQ-032 A simultaneous push and pop SHALL leave occupancy unchanged.
REQ-033 Pointers SHALL wrap modulo 4.

Reset
REQ-034 On rst, the state SHALL go to IDLE, FIFO occupancy and in-flight count SHALL be 0, rd_addr SHALL be 0, and rd_en, dst_valid, dst_last, busy and done SHALL be 0.
REQ-035 dst_data SHALL reset to 0.
REQ-036 rst during RUN or DRAIN SHALL abort the transfer immediately: no further beats, no done pulse, and a rd_data return that follows reset SHALL be discarded.

Structure
REQ-037 Shared package dnn_pkg SHALL hold DW, AW, the FIFO depth constant (4) and the state enum typedef.
REQ-038 The FIFO SHALL be the one sub-module, dst_fifo, with push, pop, full, empty, count and an async-reset pointer.
REQ-039 The read issue logic, state machine and ReLU SHALL live in dst_stream.

Verification
REQ-040 ds=8, relu=0, buffer[i]=i as fp32, dst_ready=1 -> 8 consecutive beats 0.0..7.0, dst_last on the 8th, done one cycle later, first dst_valid after E2.
REQ-041 ds=6, relu=1, buffer = {1.5, -2.0, -0.0, 0.0, -1e-38, 3.0} -> beats {3FC00000, 00000000, 00000000, 00000000, 00000000, 40400000}.
REQ-042 ds=16, random dst_ready at 30% duty -> all 16 words in order, data stable while stalled, rd_en never issued with occupancy+inflight=4, no loss.
REQ-043 start with ds=0 -> no dst_valid, done pulses once; a start during busy -> ignored and the word count is unchanged.
REQ-044 rst asserted after the 3rd handshake of ds=10 -> all outputs 0 next cycle and no done; a fresh start with ds=2 afterwards -> exactly 2 beats from address 0.
REQ-045 ds=4095 with dst_ready=1 -> 4095 beats in 4095 consecutive cycles, rd_addr ends at 4094, dst_last once.
